// File: rtl/alu_pipe_pkg.sv
// Shared definitions for alu_pipe: command codes for both modes, FSM state codes,
// the status-flag bundle and the operand-requirement decode helpers.
package alu_pipe_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  // Arithmetic mode (mode=1)
  localparam logic [3:0] A_ADD     = 4'd0;
  localparam logic [3:0] A_SUB     = 4'd1;
  localparam logic [3:0] A_ADD_CIN = 4'd2;
  localparam logic [3:0] A_SUB_CIN = 4'd3;
  localparam logic [3:0] A_INC_A   = 4'd4;
  localparam logic [3:0] A_DEC_A   = 4'd5;
  localparam logic [3:0] A_INC_B   = 4'd6;
  localparam logic [3:0] A_DEC_B   = 4'd7;
  localparam logic [3:0] A_CMP     = 4'd8;
  localparam logic [3:0] A_MUL_INC = 4'd9;
  localparam logic [3:0] A_MUL_SHL = 4'd10;

  // Logical mode (mode=0)
  localparam logic [3:0] L_AND    = 4'd0;
  localparam logic [3:0] L_NAND   = 4'd1;
  localparam logic [3:0] L_OR     = 4'd2;
  localparam logic [3:0] L_NOR    = 4'd3;
  localparam logic [3:0] L_XOR    = 4'd4;
  localparam logic [3:0] L_XNOR   = 4'd5;
  localparam logic [3:0] L_NOT_A  = 4'd6;
  localparam logic [3:0] L_NOT_B  = 4'd7;
  localparam logic [3:0] L_SHR1_A = 4'd8;
  localparam logic [3:0] L_SHL1_A = 4'd9;
  localparam logic [3:0] L_SHR1_B = 4'd10;
  localparam logic [3:0] L_SHL1_B = 4'd11;
  localparam logic [3:0] L_ROL    = 4'd12;
  localparam logic [3:0] L_ROR    = 4'd13;

  typedef struct packed {
    logic cout;
    logic oflow;
    logic err;
    logic g;
    logic l;
    logic e;
  } alu_flags_t;

  function automatic logic cmd_defined(input logic mode, input logic [3:0] cmd);
    return mode ? (cmd <= A_MUL_SHL) : (cmd <= L_ROR);
  endfunction

  function automatic logic needs_a(input logic mode, input logic [3:0] cmd);
    if (mode) return !(cmd == A_INC_B || cmd == A_DEC_B);
    return !(cmd == L_NOT_B || cmd == L_SHR1_B || cmd == L_SHL1_B);
  endfunction

  function automatic logic needs_b(input logic mode, input logic [3:0] cmd);
    if (mode) return !(cmd == A_INC_A || cmd == A_DEC_A);
    return !(cmd == L_NOT_A || cmd == L_SHR1_A || cmd == L_SHL1_A);
  endfunction

  function automatic logic is_mul(input logic mode, input logic [3:0] cmd);
    return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Purely combinational ALU datapath: computes RES and status flags from one operand set.
// Any error condition forces RES=0 with only ERR set and suppresses the multiply path.
module alu_pipe_core
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4
) (
  input  logic                    mode,
  input  logic [1:0]              inp_valid,
  input  logic [CMD_WIDTH-1:0]    cmd,
  input  logic [DATA_WIDTH-1:0]   opa,
  input  logic [DATA_WIDTH-1:0]   opb,
  input  logic                    cin,
  output logic [2*DATA_WIDTH:0]   res,
  output alu_flags_t              flags,
  output logic                    mul_go
);
  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam int RW = 2 * W + 1;
  localparam logic [W:0] ONE = (W + 1)'(1);

  logic [3:0]    c4;
  logic          hi_cmd;
  logic          rot_err;
  logic          bad;
  logic [W:0]    a_x, b_x, cin_x, t;
  logic [W-1:0]  lv, a_shl, rol_v, ror_v;
  logic [SW-1:0] sh;
  logic [SW:0]   inv_sh;
  logic [2*W-1:0] prod_inc, prod_shl;

  assign c4 = cmd[3:0];

  // Command codes wider than the defined set are always undefined
  if (CMD_WIDTH > 4) begin : g_hi_cmd
    assign hi_cmd = |cmd[CMD_WIDTH-1:4];
  end else begin : g_no_hi_cmd
    assign hi_cmd = 1'b0;
  end

  assign a_x    = {1'b0, opa};
  assign b_x    = {1'b0, opb};
  assign cin_x  = {{W{1'b0}}, cin};
  assign a_shl  = {opa[W-2:0], 1'b0};
  assign prod_inc = {{(W-1){1'b0}}, a_x + ONE} * {{(W-1){1'b0}}, b_x + ONE};
  assign prod_shl = {{W{1'b0}}, a_shl} * {{W{1'b0}}, opb};

  assign sh     = opb[SW-1:0];
  assign inv_sh = (SW + 1)'(W) - {1'b0, sh};
  assign rol_v  = (opa << sh) | (opa >> inv_sh);
  assign ror_v  = (opa >> sh) | (opa << inv_sh);
  assign rot_err = !mode && (c4 == L_ROL || c4 == L_ROR) && (|opb[W-1:SW]);

  assign bad = hi_cmd || !cmd_defined(mode, c4)
            || (needs_a(mode, c4) && !inp_valid[0])
            || (needs_b(mode, c4) && !inp_valid[1])
            || rot_err;

  function automatic logic [RW-1:0] zx1(input logic [W:0] v);
    return {{W{1'b0}}, v};
  endfunction

  function automatic logic [RW-1:0] zx(input logic [W-1:0] v);
    return {{(W + 1){1'b0}}, v};
  endfunction

  always_comb begin
    res    = '0;
    flags  = '0;
    mul_go = 1'b0;
    t      = '0;
    lv     = '0;
    if (mode) begin
      case (c4)
        A_ADD:     begin t = a_x + b_x;         res = zx1(t);        flags.cout  = t[W]; end
        A_SUB:     begin t = a_x - b_x;         res = zx(t[W-1:0]);  flags.oflow = t[W]; end
        A_ADD_CIN: begin t = a_x + b_x + cin_x; res = zx1(t);        flags.cout  = t[W]; end
        A_SUB_CIN: begin t = a_x - b_x - cin_x; res = zx(t[W-1:0]);  flags.oflow = t[W]; end
        A_INC_A:   begin t = a_x + ONE;         res = zx1(t);        flags.cout  = t[W]; end
        A_DEC_A:   begin t = a_x - ONE;         res = zx(t[W-1:0]);  flags.oflow = t[W]; end
        A_INC_B:   begin t = b_x + ONE;         res = zx1(t);        flags.cout  = t[W]; end
        A_DEC_B:   begin t = b_x - ONE;         res = zx(t[W-1:0]);  flags.oflow = t[W]; end
        A_CMP: begin
          flags.g = (opa > opb);
          flags.l = (opa < opb);
          flags.e = (opa == opb);
        end
        A_MUL_INC: begin res = {1'b0, prod_inc}; mul_go = 1'b1; end
        A_MUL_SHL: begin res = {1'b0, prod_shl}; mul_go = 1'b1; end
        default: ;
      endcase
    end else begin
      case (c4)
        L_AND:    lv = opa & opb;
        L_NAND:   lv = ~(opa & opb);
        L_OR:     lv = opa | opb;
        L_NOR:    lv = ~(opa | opb);
        L_XOR:    lv = opa ^ opb;
        L_XNOR:   lv = ~(opa ^ opb);
        L_NOT_A:  lv = ~opa;
        L_NOT_B:  lv = ~opb;
        L_SHR1_A: lv = opa >> 1;
        L_SHL1_A: lv = opa << 1;
        L_SHR1_B: lv = opb >> 1;
        L_SHL1_B: lv = opb << 1;
        L_ROL:    lv = rol_v;
        L_ROR:    lv = ror_v;
        default:  lv = '0;
      endcase
      res = zx(lv);
    end
    if (bad) begin
      res       = '0;
      flags     = '0;
      flags.err = 1'b1;
      mul_go    = 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU wrapper: request acceptance, IDLE/MUL sequencing with a latency counter,
// and a held output register with valid/ready back-pressure.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CMD_WIDTH   = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CE,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [1:0]            INP_VALID,
  input  logic [CMD_WIDTH-1:0]  CMD,
  input  logic [DATA_WIDTH-1:0] opa,
  input  logic [DATA_WIDTH-1:0] opb,
  input  logic                  CIN,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*DATA_WIDTH:0] RES,
  output logic                  cout,
  output logic                  OFLOW,
  output logic                  ERR,
  output logic                  g,
  output logic                  l,
  output logic                  e
);
  localparam int CNT_W = $clog2(MUL_LATENCY);

  logic [0:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  mode_reg;
  logic [1:0]            inp_valid_reg;
  logic [CMD_WIDTH-1:0]  cmd_reg;
  logic [DATA_WIDTH-1:0] opa_reg, opb_reg;
  logic                  cin_reg;
  logic                  out_valid_reg;
  logic [2*DATA_WIDTH:0] res_reg;
  alu_flags_t            flags_reg;

  logic                  in_mul, accept, mul_done, load_out;
  logic                  core_mode, core_cin, core_mul;
  logic [1:0]            core_inp_valid;
  logic [CMD_WIDTH-1:0]  core_cmd;
  logic [DATA_WIDTH-1:0] core_opa, core_opb;
  logic [2*DATA_WIDTH:0] core_res;
  alu_flags_t            core_flags;

  assign in_mul   = (state_reg == ST_MUL);
  assign in_ready = !rst && (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready && CE;

  // One shared datapath: live request while idle, captured operands while multiplying
  assign core_mode      = in_mul ? mode_reg      : mode;
  assign core_inp_valid = in_mul ? inp_valid_reg : INP_VALID;
  assign core_cmd       = in_mul ? cmd_reg       : CMD;
  assign core_opa       = in_mul ? opa_reg       : opa;
  assign core_opb       = in_mul ? opb_reg       : opb;
  assign core_cin       = in_mul ? cin_reg       : CIN;

  alu_pipe_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMD_WIDTH  (CMD_WIDTH)
  ) u_core (
    .mode      (core_mode),
    .inp_valid (core_inp_valid),
    .cmd       (core_cmd),
    .opa       (core_opa),
    .opb       (core_opb),
    .cin       (core_cin),
    .res       (core_res),
    .flags     (core_flags),
    .mul_go    (core_mul)
  );

  assign mul_done = in_mul && CE && (cnt_reg == '0);
  assign load_out = (accept && !core_mul) || mul_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      res_reg       <= '0;
      flags_reg     <= '0;
    end else begin
      if (accept) begin
        mode_reg      <= mode;
        inp_valid_reg <= INP_VALID;
        cmd_reg       <= CMD;
        opa_reg       <= opa;
        opb_reg       <= opb;
        cin_reg       <= CIN;
        if (core_mul) begin
          state_reg <= ST_MUL;
          cnt_reg   <= CNT_W'(MUL_LATENCY - 1);
        end
      end
      if (in_mul && CE) begin
        if (cnt_reg == '0) state_reg <= ST_IDLE;
        else               cnt_reg   <= cnt_reg - 1'b1;
      end
      if (load_out) begin
        res_reg       <= core_res;
        flags_reg     <= core_flags;
        out_valid_reg <= 1'b1;
      end else if (CE && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign RES       = res_reg;
  assign cout      = flags_reg.cout;
  assign OFLOW     = flags_reg.oflow;
  assign ERR       = flags_reg.err;
  assign g         = flags_reg.g;
  assign l         = flags_reg.l;
  assign e         = flags_reg.e;

endmodule
